// File: rtl/spi_cfg_ctrl_pkg.sv
// Shared definitions for the SPI configuration controller: FSM states,
// datapath register indices and the read-only status address helper.
package spi_cfg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  // Register indices consumed by the signal-processing datapath
  localparam int REG_GAIN   = 0;
  localparam int REG_OFFSET = 1;
  localparam int REG_THRESH = 2;
  localparam int REG_MODE   = 3;

  // The top address of the register map is the live, read-only status word
  function automatic int status_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/spi_cfg_regfile.sv
// Configuration register file: one write port, one async read port that
// substitutes live status at the top address, and a flattened view.
module spi_cfg_regfile
  import spi_cfg_ctrl_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [ADDR_W-1:0]              raddr,
  input  logic [DATA_W-1:0]              status_in,
  output logic [DATA_W-1:0]              rdata,
  output logic [(2**ADDR_W)*DATA_W-1:0]  cfg_regs
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(status_addr(ADDR_W));

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (we && (waddr != ADDR_STATUS)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == ADDR_STATUS) ? status_in : regs[raddr];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: rtl/spi_cfg_ctrl.sv
// Command-frame controller behind the SPI slave: decodes header words into
// register writes/reads, drives readback data and tracks frame errors.
module spi_cfg_ctrl
  import spi_cfg_ctrl_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cs_n,
  input  logic                           word_valid,
  input  logic [DATA_W-1:0]              word_in,
  input  logic [DATA_W-1:0]              status_in,
  output logic [DATA_W-1:0]              po_data,
  output logic [(2**ADDR_W)*DATA_W-1:0]  cfg_regs,
  output logic                           wr_strobe,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic                           busy,
  output logic                           err_timeout,
  output logic [7:0]                     err_cnt
);

  localparam int HDR_RW    = DATA_W - 1;
  localparam int HDR_BURST = DATA_W - 2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(status_addr(ADDR_W));
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx, raddr;
  logic              burst, burst_nx;
  logic              seen_data, seen_data_nx;
  logic [TCNT_W-1:0] tcnt, tcnt_nx;
  logic [DATA_W-1:0] po_data_nx, rdata;
  logic              rf_we, timeout_nx, err_inc;

  spi_cfg_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (ptr),
    .wdata     (word_in),
    .raddr     (raddr),
    .status_in (status_in),
    .rdata     (rdata),
    .cfg_regs  (cfg_regs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      burst       <= 1'b0;
      seen_data   <= 1'b0;
      tcnt        <= '0;
      po_data     <= '0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      err_timeout <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      burst       <= burst_nx;
      seen_data   <= seen_data_nx;
      tcnt        <= tcnt_nx;
      po_data     <= po_data_nx;
      wr_strobe   <= rf_we;
      err_timeout <= timeout_nx;
      if (rf_we) wr_addr <= ptr;
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Chip-select abort dominates everything; a word arriving in the expiry cycle beats the timeout
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    burst_nx     = burst;
    seen_data_nx = seen_data;
    tcnt_nx      = '0;
    po_data_nx   = po_data;
    rf_we        = 1'b0;
    timeout_nx   = 1'b0;
    err_inc      = 1'b0;
    raddr        = ptr + ADDR_W'(1);

    if (cs_n) begin
      state_nx   = ST_IDLE;
      po_data_nx = '0;
      err_inc    = (state != ST_IDLE) && !seen_data;
    end else begin
      case (state)
        ST_IDLE: begin
          raddr = word_in[ADDR_W-1:0];
          if (word_valid) begin
            ptr_nx       = word_in[ADDR_W-1:0];
            burst_nx     = word_in[HDR_BURST];
            seen_data_nx = 1'b0;
            if (word_in[HDR_RW]) begin
              state_nx = ST_WR;
            end else begin
              state_nx   = ST_RD;
              po_data_nx = rdata;
            end
          end
        end
        ST_WR: begin
          if (word_valid) begin
            rf_we        = (ptr != ADDR_STATUS);
            seen_data_nx = 1'b1;
            if (burst) ptr_nx = ptr + ADDR_W'(1);
            else       state_nx = ST_IDLE;
          end
        end
        ST_RD: begin
          if (word_valid) begin
            seen_data_nx = 1'b1;
            if (burst) begin
              ptr_nx     = ptr + ADDR_W'(1);
              po_data_nx = rdata;
            end else begin
              po_data_nx = '0;
              state_nx   = ST_IDLE;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase

      if ((state != ST_IDLE) && !word_valid) begin
        if (tcnt == TCNT_LAST) begin
          state_nx   = ST_IDLE;
          po_data_nx = '0;
          timeout_nx = 1'b1;
          err_inc    = 1'b1;
        end else begin
          tcnt_nx = tcnt + TCNT_W'(1);
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Directed self-checking bench for spi_cfg_ctrl: writes, reads, bursts,
// status readback, timeout, abort and asynchronous reset.
module tb_spi_cfg_ctrl;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 4;
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int T = 32;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       cs_n = 1'b1;
  logic                       word_valid = 1'b0;
  logic [DATA_W-1:0]          word_in = '0;
  logic [DATA_W-1:0]          status_in = '0;
  logic [DATA_W-1:0]          po_data;
  logic [NUM_REGS*DATA_W-1:0] cfg_regs;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       busy;
  logic                       err_timeout;
  logic [7:0]                 err_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int timeout_cnt = 0;

  spi_cfg_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_n        (cs_n),
    .word_valid  (word_valid),
    .word_in     (word_in),
    .status_in   (status_in),
    .po_data     (po_data),
    .cfg_regs    (cfg_regs),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    if (err_timeout) timeout_cnt <= timeout_cnt + 1;
  end

  function automatic logic [DATA_W-1:0] reg_of(input int k);
    return cfg_regs[k*DATA_W +: DATA_W];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One-cycle word_valid pulse; returns #1 after the edge that consumed the word
  task automatic applyStimulus(input logic [DATA_W-1:0] w);
    word_in    = w;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
  endtask

  initial begin
    int base, cycles;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_po_data", 32'(po_data), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
    checkOutput("rst_cfg_reg3", 32'(reg_of(3)), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cs_n = 1'b0;

    $display("[TB] single write");
    applyStimulus(10'h203);
    checkOutput("wr_hdr_busy", 32'(busy), 32'h1);
    applyStimulus(10'h155);
    checkOutput("wr_strobe", 32'(wr_strobe), 32'h1);
    checkOutput("wr_addr", 32'(wr_addr), 32'h3);
    checkOutput("wr_reg3", 32'(reg_of(3)), 32'h155);
    checkOutput("wr_busy_done", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("wr_strobe_1cyc", 32'(wr_strobe), 32'h0);

    $display("[TB] single read");
    applyStimulus(10'h003);
    checkOutput("rd_po_data", 32'(po_data), 32'h155);
    checkOutput("rd_busy", 32'(busy), 32'h1);
    applyStimulus(10'h000);
    checkOutput("rd_po_clear", 32'(po_data), 32'h0);
    checkOutput("rd_busy_done", 32'(busy), 32'h0);

    $display("[TB] burst write with wrap");
    base = strobe_cnt;
    applyStimulus(10'h30E);
    applyStimulus(10'h001);
    applyStimulus(10'h002);
    applyStimulus(10'h003);
    @(posedge clk);
    #1;
    checkOutput("bw_reg14", 32'(reg_of(14)), 32'h1);
    checkOutput("bw_reg15_dropped", 32'(reg_of(15)), 32'h0);
    checkOutput("bw_reg0_wrap", 32'(reg_of(0)), 32'h3);
    checkOutput("bw_strobes", 32'(strobe_cnt - base), 32'd2);
    checkOutput("bw_still_busy", 32'(busy), 32'h1);
    cs_n = 1'b1;
    @(posedge clk);
    #1;
    cs_n = 1'b0;
    checkOutput("bw_end_busy", 32'(busy), 32'h0);
    checkOutput("bw_end_err", 32'(err_cnt), 32'h0);

    $display("[TB] burst read through status and wrap");
    status_in = 10'h2AA;
    applyStimulus(10'h10E);
    checkOutput("br_reg14", 32'(po_data), 32'h1);
    applyStimulus(10'h000);
    checkOutput("br_status", 32'(po_data), 32'h2AA);
    applyStimulus(10'h000);
    checkOutput("br_wrap_reg0", 32'(po_data), 32'h3);
    cs_n = 1'b1;
    @(posedge clk);
    #1;
    cs_n = 1'b0;
    checkOutput("br_abort_po", 32'(po_data), 32'h0);
    checkOutput("br_abort_err", 32'(err_cnt), 32'h0);

    $display("[TB] status read");
    status_in = 10'h2AA;
    applyStimulus(10'h00F);
    checkOutput("st_po_data", 32'(po_data), 32'h2AA);
    applyStimulus(10'h000);

    $display("[TB] timeout");
    base = timeout_cnt;
    applyStimulus(10'h201);
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < T + 10; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (err_timeout) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("to_seen", 32'(seen), 32'h1);
    checkOutput("to_latency", 32'(cycles), 32'(T));
    checkOutput("to_err_cnt", 32'(err_cnt), 32'h1);
    checkOutput("to_busy", 32'(busy), 32'h0);
    applyStimulus(10'h003);
    checkOutput("to_next_hdr_po", 32'(po_data), 32'h155);
    checkOutput("to_next_hdr_busy", 32'(busy), 32'h1);
    applyStimulus(10'h000);

    $display("[TB] word at timeout expiry");
    base = timeout_cnt;
    applyStimulus(10'h201);
    repeat (T - 1) @(posedge clk);
    #1;
    applyStimulus(10'h0C3);
    checkOutput("tw_reg1", 32'(reg_of(1)), 32'h0C3);
    checkOutput("tw_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("tw_no_timeout", 32'(timeout_cnt - base), 32'd0);
    checkOutput("tw_err_cnt", 32'(err_cnt), 32'h1);

    $display("[TB] abort with coincident word");
    applyStimulus(10'h202);
    cs_n       = 1'b1;
    word_in    = 10'h3FF;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    checkOutput("ab_busy", 32'(busy), 32'h0);
    checkOutput("ab_err_cnt", 32'(err_cnt), 32'h2);
    checkOutput("ab_reg2", 32'(reg_of(2)), 32'h0);
    checkOutput("ab_no_strobe", 32'(wr_strobe), 32'h0);
    cs_n = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset mid-burst");
    applyStimulus(10'h301);
    applyStimulus(10'h0AB);
    checkOutput("rb_reg1", 32'(reg_of(1)), 32'h0AB);
    checkOutput("rb_strobe", 32'(wr_strobe), 32'h1);
    rst_n = 1'b0;
    #2;
    checkOutput("rb_reg1_clr", 32'(reg_of(1)), 32'h0);
    checkOutput("rb_reg3_clr", 32'(reg_of(3)), 32'h0);
    checkOutput("rb_busy", 32'(busy), 32'h0);
    checkOutput("rb_strobe_clr", 32'(wr_strobe), 32'h0);
    checkOutput("rb_wr_addr", 32'(wr_addr), 32'h0);
    checkOutput("rb_err_cnt", 32'(err_cnt), 32'h0);
    checkOutput("rb_po_data", 32'(po_data), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
